// File: rtl/axi_lite_arbiter_pkg.sv
// Shared bus definitions for the IFU/LSU AXI4-Lite arbiter.
package axi_lite_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD_M0 = 2'd1,
      ST_RD_M1 = 2'd2,
      ST_WR_M1 = 2'd3
   } arb_state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [3:0] IFU_RSTRB_DEF = 4'b1111;

   localparam logic GNT_M0 = 1'b0;
   localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction in flight; LSU writes first, reads round-robin.
module axi_lite_arbiter
   import axi_lite_arbiter_pkg::*;
#(
   parameter logic [3:0] IFU_RSTRB = IFU_RSTRB_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_ARVALID,
   output logic        m0_ARREADY,
   input  logic [31:0] m0_ARADDR,
   output logic        m0_RVALID,
   input  logic        m0_RREADY,
   output logic [31:0] m0_RDATA,
   output logic [1:0]  m0_RRESP,
   input  logic        m1_ARVALID,
   output logic        m1_ARREADY,
   input  logic [31:0] m1_ARADDR,
   output logic        m1_RVALID,
   input  logic        m1_RREADY,
   output logic [31:0] m1_RDATA,
   output logic [1:0]  m1_RRESP,
   input  logic        m1_AWVALID,
   output logic        m1_AWREADY,
   input  logic [31:0] m1_AWADDR,
   input  logic        m1_WVALID,
   output logic        m1_WREADY,
   input  logic [31:0] m1_WDATA,
   input  logic [3:0]  m1_WSTRB,
   output logic        m1_BVALID,
   input  logic        m1_BREADY,
   output logic [1:0]  m1_BRESP,
   output logic        s_ARVALID,
   input  logic        s_ARREADY,
   output logic [31:0] s_ARADDR,
   input  logic        s_RVALID,
   output logic        s_RREADY,
   input  logic [31:0] s_RDATA,
   input  logic [1:0]  s_RRESP,
   output logic        s_AWVALID,
   input  logic        s_AWREADY,
   output logic [31:0] s_AWADDR,
   output logic        s_WVALID,
   input  logic        s_WREADY,
   output logic [31:0] s_WDATA,
   output logic [3:0]  s_WSTRB,
   input  logic        s_BVALID,
   output logic        s_BREADY,
   input  logic [1:0]  s_BRESP
);

   arb_state_e state_q, state_d;
   logic       ar_done_q, ar_done_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
   logic       last_grant_q, last_grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ar_done_q    <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         last_grant_q <= GNT_M1;
      end else begin
         state_q      <= state_d;
         ar_done_q    <= ar_done_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ar_done_d    = ar_done_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         ST_IDLE: begin
            // m0 wins a tie only when m1 held the previous read grant
            if (m1_AWVALID || m1_WVALID) begin
               state_d = ST_WR_M1;
            end else if (m0_ARVALID &&
                         (!m1_ARVALID || last_grant_q == GNT_M1)) begin
               state_d      = ST_RD_M0;
               last_grant_d = GNT_M0;
            end else if (m1_ARVALID) begin
               state_d      = ST_RD_M1;
               last_grant_d = GNT_M1;
            end
         end
         ST_RD_M0, ST_RD_M1: begin
            if (s_ARVALID && s_ARREADY) ar_done_d = 1'b1;
            if (s_RVALID && s_RREADY) begin
               state_d   = ST_IDLE;
               ar_done_d = 1'b0;
            end
         end
         ST_WR_M1: begin
            if (s_AWVALID && s_AWREADY) aw_done_d = 1'b1;
            if (s_WVALID && s_WREADY)   w_done_d  = 1'b1;
            if (s_BVALID && s_BREADY) begin
               state_d   = ST_IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      m0_ARREADY = 1'b0;
      m0_RVALID  = 1'b0;
      m0_RDATA   = '0;
      m0_RRESP   = AXI_RESP_OKAY;
      m1_ARREADY = 1'b0;
      m1_RVALID  = 1'b0;
      m1_RDATA   = '0;
      m1_RRESP   = AXI_RESP_OKAY;
      m1_AWREADY = 1'b0;
      m1_WREADY  = 1'b0;
      m1_BVALID  = 1'b0;
      m1_BRESP   = AXI_RESP_OKAY;
      s_ARVALID  = 1'b0;
      s_ARADDR   = '0;
      s_RREADY   = 1'b0;
      s_AWVALID  = 1'b0;
      s_AWADDR   = '0;
      s_WVALID   = 1'b0;
      s_WDATA    = '0;
      s_WSTRB    = m1_WSTRB;
      s_BREADY   = 1'b0;
      unique case (state_q)
         ST_RD_M0: begin
            s_ARVALID  = m0_ARVALID & ~ar_done_q;
            s_ARADDR   = m0_ARADDR;
            m0_ARREADY = s_ARREADY & ~ar_done_q;
            m0_RVALID  = s_RVALID;
            m0_RDATA   = s_RDATA;
            m0_RRESP   = s_RRESP;
            s_RREADY   = m0_RREADY;
            s_WSTRB    = IFU_RSTRB;
         end
         ST_RD_M1: begin
            s_ARVALID  = m1_ARVALID & ~ar_done_q;
            s_ARADDR   = m1_ARADDR;
            m1_ARREADY = s_ARREADY & ~ar_done_q;
            m1_RVALID  = s_RVALID;
            m1_RDATA   = s_RDATA;
            m1_RRESP   = s_RRESP;
            s_RREADY   = m1_RREADY;
         end
         ST_WR_M1: begin
            s_AWVALID  = m1_AWVALID & ~aw_done_q;
            s_AWADDR   = m1_AWADDR;
            m1_AWREADY = s_AWREADY & ~aw_done_q;
            s_WVALID   = m1_WVALID & ~w_done_q;
            s_WDATA    = m1_WDATA;
            m1_WREADY  = s_WREADY & ~w_done_q;
            m1_BVALID  = s_BVALID;
            m1_BRESP   = s_BRESP;
            s_BREADY   = m1_BREADY;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with a single-process slave/master model.
module tb_axi_lite_arbiter;
   import axi_lite_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic m0_ARVALID, m0_ARREADY, m0_RVALID, m0_RREADY;
   logic [31:0] m0_ARADDR, m0_RDATA;
   logic [1:0] m0_RRESP;
   logic m1_ARVALID, m1_ARREADY, m1_RVALID, m1_RREADY;
   logic [31:0] m1_ARADDR, m1_RDATA;
   logic [1:0] m1_RRESP;
   logic m1_AWVALID, m1_AWREADY, m1_WVALID, m1_WREADY;
   logic [31:0] m1_AWADDR, m1_WDATA;
   logic [3:0] m1_WSTRB;
   logic m1_BVALID, m1_BREADY;
   logic [1:0] m1_BRESP;
   logic s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
   logic [31:0] s_ARADDR, s_RDATA;
   logic [1:0] s_RRESP;
   logic s_AWVALID, s_AWREADY, s_WVALID, s_WREADY;
   logic [31:0] s_AWADDR, s_WDATA;
   logic [3:0] s_WSTRB;
   logic s_BVALID, s_BREADY;
   logic [1:0] s_BRESP;

   axi_lite_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY), .m0_ARADDR(m0_ARADDR),
      .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY), .m0_RDATA(m0_RDATA),
      .m0_RRESP(m0_RRESP),
      .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY), .m1_ARADDR(m1_ARADDR),
      .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY), .m1_RDATA(m1_RDATA),
      .m1_RRESP(m1_RRESP),
      .m1_AWVALID(m1_AWVALID), .m1_AWREADY(m1_AWREADY), .m1_AWADDR(m1_AWADDR),
      .m1_WVALID(m1_WVALID), .m1_WREADY(m1_WREADY), .m1_WDATA(m1_WDATA),
      .m1_WSTRB(m1_WSTRB),
      .m1_BVALID(m1_BVALID), .m1_BREADY(m1_BREADY), .m1_BRESP(m1_BRESP),
      .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR),
      .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA),
      .s_RRESP(s_RRESP),
      .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR),
      .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA),
      .s_WSTRB(s_WSTRB),
      .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP)
   );

   always #5 clk = ~clk;

   logic [11:0] outs_w;
   assign outs_w = {m0_ARREADY, m0_RVALID, m1_ARREADY, m1_RVALID,
                    m1_AWREADY, m1_WREADY, m1_BVALID, s_ARVALID,
                    s_RREADY, s_AWVALID, s_WVALID, s_BREADY};

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int r0_n = 0, r1_n = 0, b_n = 0, rv0_n = 0, rv1_n = 0;
   int m1rv_n = 0, m1ar_n = 0, wr_n = 0;
   int sar_rise = 0, b_cyc = 0;
   int rep0 = 0, rep1 = 0;
   int order[$];
   logic [31:0] r0_d, r1_d, w_addr, w_data;
   logic [3:0] w_strb, strb_rd;
   logic [1:0] bresp;
   logic prev_sarv = 1'b0;
   logic [11:0] outs_n;
   logic [31:0] st_n;
   logic sarv_n;
   logic [3:0] sstrb_n;
   logic rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
   int rd_cnt = 0;
   logic [31:0] rd_addr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: observe at negedge, then update models just after posedge.
   task automatic tick();
      logic rs, arh, rh, awh, wh, bh, m0h, m1h, m1awh, m1wh;
      logic [31:0] ara, awa, wd;
      logic [3:0] ws;
      @(negedge clk);
      rs = rst;
      arh = s_ARVALID & s_ARREADY;  ara = s_ARADDR;
      rh = s_RVALID & s_RREADY;
      awh = s_AWVALID & s_AWREADY;  awa = s_AWADDR;
      wh = s_WVALID & s_WREADY;     wd = s_WDATA;  ws = s_WSTRB;
      bh = s_BVALID & s_BREADY;
      m0h = m0_ARVALID & m0_ARREADY;
      m1h = m1_ARVALID & m1_ARREADY;
      m1awh = m1_AWVALID & m1_AWREADY;
      m1wh = m1_WVALID & m1_WREADY;
      if (m0_RVALID && m0_RREADY) begin
         r0_n++; r0_d = m0_RDATA; order.push_back(0);
      end
      if (m1_RVALID && m1_RREADY) begin
         r1_n++; r1_d = m1_RDATA; order.push_back(1);
      end
      if (m1_BVALID && m1_BREADY) begin
         b_n++; bresp = m1_BRESP; b_cyc = cyc;
      end
      if (m0_RVALID) rv0_n++;
      if (m1_RVALID) rv1_n++;
      if (m1_ARREADY) m1ar_n++;
      if (s_ARVALID && !prev_sarv) sar_rise = cyc;
      prev_sarv = s_ARVALID;
      if (s_ARVALID) strb_rd = s_WSTRB;
      outs_n = outs_w;
      st_n = 32'(dut.state_q);
      sarv_n = s_ARVALID;
      sstrb_n = s_WSTRB;
      @(posedge clk);
      #1;
      cyc++;
      if (rs) begin
         s_RVALID = 1'b0; rd_pend = 1'b0;
         aw_got = 1'b0; w_got = 1'b0; s_BVALID = 1'b0;
      end else begin
         if (rh) s_RVALID = 1'b0;
         if (rd_pend) begin
            if (rd_cnt == 0) begin
               s_RVALID = 1'b1; s_RDATA = ~rd_addr; rd_pend = 1'b0;
            end else rd_cnt--;
         end
         if (arh) begin
            rd_pend = 1'b1; rd_cnt = 1; rd_addr = ara;
         end
         if (bh) s_BVALID = 1'b0;
         if (awh) begin aw_got = 1'b1; w_addr = awa; end
         if (wh) begin w_got = 1'b1; w_data = wd; w_strb = ws; end
         if (aw_got && w_got && !s_BVALID) begin
            s_BVALID = 1'b1; wr_n++; aw_got = 1'b0; w_got = 1'b0;
         end
      end
      if (m0h) begin if (rep0 > 0) rep0--; else m0_ARVALID = 1'b0; end
      if (m1h) begin if (rep1 > 0) rep1--; else m1_ARVALID = 1'b0; end
      if (m1awh) m1_AWVALID = 1'b0;
      if (m1wh) m1_WVALID = 1'b0;
   endtask

   function automatic int cnt(input int sel);
      case (sel)
         0: return r0_n;
         1: return r1_n;
         2: return b_n;
         3: return rv0_n;
         default: return rv1_n;
      endcase
   endfunction

   task automatic wait_cnt(input string tag, input int sel, input int target);
      int i;
      for (i = 0; i < 200 && cnt(sel) < target; i++) tick();
      chk(tag, 32'(cnt(sel) >= target), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int b0, b1, bo, bw, bm;
      int exp_ord [6] = '{0, 1, 0, 1, 0, 1};
      rst = 1'b1;
      m0_ARVALID = 0; m0_ARADDR = 0; m0_RREADY = 1;
      m1_ARVALID = 0; m1_ARADDR = 0; m1_RREADY = 1;
      m1_AWVALID = 0; m1_AWADDR = 0; m1_WVALID = 0; m1_WDATA = 0;
      m1_WSTRB = 4'h3; m1_BREADY = 1;
      s_ARREADY = 1; s_AWREADY = 1; s_WREADY = 1;
      s_RVALID = 0; s_RDATA = 0; s_RRESP = 2'b00;
      s_BVALID = 0; s_BRESP = 2'b00;
      do_reset();
      tick();
      chk("reset_outs", 32'(outs_n), 32'd0);
      chk("reset_state", st_n, 32'(ST_IDLE));
      chk("idle_wstrb", 32'(sstrb_n), 32'h3);

      // lone m0 read
      b0 = r0_n; bm = m1rv_n + rv1_n;
      m0_ARADDR = 32'h8000_0000; m0_ARVALID = 1'b1;
      tick();
      chk("grant_registered", 32'(sarv_n), 32'd0);
      wait_cnt("m0_read_done", 0, b0 + 1);
      chk("m0_rdata", r0_d, 32'h7FFF_FFFF);
      chk("m1_rvalid_quiet", 32'(rv1_n), 32'(bm));
      chk("rd_m0_wstrb", 32'(strb_rd), 32'hF);
      tick();
      chk("idle_after_read", st_n, 32'(ST_IDLE));

      // repeated ties from reset alternate, m0 first
      do_reset();
      b0 = r0_n; b1 = r1_n; bo = order.size();
      rep0 = 2; rep1 = 2;
      m0_ARADDR = 32'h8000_0000; m1_ARADDR = 32'h8000_0100;
      m0_ARVALID = 1'b1; m1_ARVALID = 1'b1;
      wait_cnt("tie_m0_done", 0, b0 + 3);
      wait_cnt("tie_m1_done", 1, b1 + 3);
      for (int i = 0; i < 6; i++) begin
         if (order.size() > bo + i) chk($sformatf("tie_order%0d", i),
                                         32'(order[bo + i]), 32'(exp_ord[i]));
         else chk($sformatf("tie_order%0d", i), 32'hFFFF_FFFF,
                  32'(exp_ord[i]));
      end
      chk("tie_m1_rdata", r1_d, 32'h7FFF_FEFF);

      // write with W two cycles after AW
      bw = wr_n; b0 = b_n;
      m1_AWADDR = 32'h8000_0200; m1_AWVALID = 1'b1;
      tick();
      tick();
      m1_WDATA = 32'hDEAD_BEEF; m1_WSTRB = 4'hF; m1_WVALID = 1'b1;
      wait_cnt("wr_b_done", 2, b0 + 1);
      repeat (3) tick();
      chk("wr_count", 32'(wr_n - bw), 32'd1);
      chk("wr_b_count", 32'(b_n - b0), 32'd1);
      chk("wr_data", w_data, 32'hDEAD_BEEF);
      chk("wr_strb", 32'(w_strb), 32'hF);
      chk("wr_addr", w_addr, 32'h8000_0200);
      chk("wr_bresp", 32'(bresp), 32'(AXI_RESP_OKAY));

      // write and m0 read together: write goes first
      b0 = b_n; b1 = r0_n;
      m1_AWADDR = 32'h8000_0204; m1_WDATA = 32'h1234_5678;
      m1_AWVALID = 1'b1; m1_WVALID = 1'b1;
      m0_ARADDR = 32'h8000_0000; m0_ARVALID = 1'b1;
      wait_cnt("wr_rd_b", 2, b0 + 1);
      wait_cnt("wr_rd_r", 0, b1 + 1);
      chk("write_before_ar", 32'(sar_rise > b_cyc), 32'd1);
      chk("wr_rd_data", w_data, 32'h1234_5678);
      chk("wr_rd_rdata", r0_d, 32'h7FFF_FFFF);

      // m0 RREADY held low blocks m1
      m0_RREADY = 1'b0;
      b0 = r0_n; b1 = r1_n;
      m0_ARADDR = 32'h8000_0300; m0_ARVALID = 1'b1;
      wait_cnt("stall_rvalid", 3, rv0_n + 1);
      m1_ARADDR = 32'h8000_0400; m1_ARVALID = 1'b1;
      bm = m1ar_n;
      repeat (5) tick();
      chk("stall_no_m1_ready", 32'(m1ar_n - bm), 32'd0);
      chk("stall_state", st_n, 32'(ST_RD_M0));
      chk("stall_no_m0_r", 32'(r0_n - b0), 32'd0);
      m0_RREADY = 1'b1;
      wait_cnt("stall_m0_done", 0, b0 + 1);
      wait_cnt("stall_m1_done", 1, b1 + 1);
      chk("stall_m0_rdata", r0_d, 32'h7FFF_FCFF);
      chk("stall_m1_rdata", r1_d, 32'h7FFF_FBFF);

      // reset while RD_M1 has R pending
      m1_RREADY = 1'b0;
      b1 = r1_n;
      m1_ARADDR = 32'h8000_0500; m1_ARVALID = 1'b1;
      wait_cnt("rst_rvalid", 4, rv1_n + 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_outs", 32'(outs_n), 32'd0);
      chk("rst_mid_state", st_n, 32'(ST_IDLE));
      m1_RREADY = 1'b1;
      b0 = r0_n;
      m0_ARADDR = 32'h8000_0600; m0_ARVALID = 1'b1;
      wait_cnt("post_rst_read", 0, b0 + 1);
      chk("post_rst_rdata", r0_d, 32'h7FFF_F9FF);
      chk("abandoned_m1", 32'(r1_n - b1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
